// File: rtl/xs3_pkg.sv
// Shared constants and types for the excess-3 digit packer.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;
  localparam logic [3:0] BCD_BAD    = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/xs3_to_bcd.sv
// Combinational excess-3 to BCD decoder. Codes outside 3..12 are flagged bad;
// the BCD output for a bad code is meaningless and is masked by the caller.
module xs3_to_bcd
  import xs3_pkg::*;
(
  input  logic [3:0] in,
  output logic [3:0] bcd,
  output logic       bad
);

  assign bcd = in - XS3_OFFSET;
  assign bad = (in < XS3_MIN) || (in > XS3_MAX);

endmodule

// File: rtl/xs3_digit_packer.sv
// Excess-3 digit packer: accepts one excess-3 digit per handshake, decodes it
// to BCD and shifts it into an NDIG-digit packed word. A word closes when it
// is full or when in_last is seen, then it is held until out_ready.
module xs3_digit_packer
  import xs3_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  input  logic              in_ovf,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [CW-1:0]     out_count,
  output logic              out_err
);

  localparam int            W          = 4 * NDIG;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NDIG - 1);

  state_e     state;
  logic [3:0] dec_bcd;
  logic       dec_bad;
  logic       bad;
  logic [3:0] nibble;
  logic       accept;

  xs3_to_bcd u_dec (
    .in  (in_digit),
    .bcd (dec_bcd),
    .bad (dec_bad)
  );

  // A digit is unusable if its code is illegal or the adder overflowed;
  // such digits are stored as a marker nibble so the position is preserved.
  assign bad    = dec_bad | in_ovf;
  assign nibble = bad ? BCD_BAD : dec_bcd;

  // Handshake strobes come from the state register; rst_n only forces
  // in_ready low so nothing is taken while reset is asserted.
  assign in_ready  = rst_n & (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Collect/hold FSM together with the shift register, digit counter and error flag.
  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block,
  // and every register here uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            out_bcd   <= {out_bcd[W-5:0], nibble};
            out_count <= out_count + CW'(1);
            out_err   <= out_err | bad;
            // The counter stops at NDIG because the word always closes there.
            if ((out_count == LAST_COUNT) || in_last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_digit_packer.sv
// Self-checking bench for xs3_digit_packer (NDIG=4): directed cases for the
// documented examples plus randomized traffic checked against a word-level model.
module tb_xs3_digit_packer;

  localparam int NDIG = 4;
  localparam int CW   = $clog2(NDIG + 1);

  typedef struct {
    logic [4*NDIG-1:0] bcd;
    logic [CW-1:0]     cnt;
    logic              err;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_digit = 4'd0;
  logic              in_ovf = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4*NDIG-1:0] out_bcd;
  logic [CW-1:0]     out_count;
  logic              out_err;

  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 1;   // 0: out_ready low, 1: out_ready high, 2: random
  int    words_seen = 0;
  word_t exp_q[$];

  // Reference accumulator for the word currently being built.
  int cur_word = 0;
  int cur_cnt = 0;
  bit cur_err = 1'b0;
  bit prev_closed = 1'b0;

  always #5 clk = ~clk;

  xs3_digit_packer #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_ovf    (in_ovf),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_count (out_count),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream ready, changed just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: every completed handshake must match the next expected word.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_bcd), 32'hFFFF_FFFF);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("word_bcd", 32'(out_bcd), 32'(e.bcd));
        check("word_count", 32'(out_count), 32'(e.cnt));
        check("word_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  // Word-level model: excess-3 value minus three, legal only when 0..9 and no overflow.
  task automatic model_accept(input logic [3:0] d, input logic o, input logic l, output bit closed);
    int v;
    bit b;
    v = int'(d) - 3;
    b = o || (v < 0) || (v > 9);
    cur_word = cur_word * 16 + (b ? 15 : v);
    cur_cnt++;
    cur_err = cur_err | b;
    closed = (cur_cnt == NDIG) || l;
    if (closed) begin
      word_t w;
      w.bcd = (4*NDIG)'(cur_word);
      w.cnt = CW'(cur_cnt);
      w.err = cur_err;
      exp_q.push_back(w);
      cur_word = 0;
      cur_cnt = 0;
      cur_err = 1'b0;
    end
  endtask

  // Called at a negedge; presents one digit, waits for acceptance and leaves
  // in_valid high so consecutive calls form an uninterrupted stream.
  task automatic send_digit(input logic [3:0] d, input logic o, input logic l, input bit chk_gap);
    int waitc;
    bit closed;
    waitc = 0;
    in_valid = 1'b1;
    in_digit = d;
    in_ovf   = o;
    in_last  = l;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    if (chk_gap) check("in_ready_gap", 32'(waitc), prev_closed ? 32'd1 : 32'd0);
    @(negedge clk);
    model_accept(d, o, l, closed);
    prev_closed = closed;
    if (closed) begin
      check("out_valid_latency", 32'(out_valid), 32'd1);
      check("in_ready_in_hold", 32'(in_ready), 32'd0);
    end else begin
      check("out_valid_early", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    cur_word = 0;
    cur_cnt = 0;
    cur_err = 1'b0;
    prev_closed = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_held(input logic [15:0] bcd, input int cnt, input logic err);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_bcd", 32'(out_bcd), 32'(bcd));
    check("held_count", 32'(out_count), 32'(cnt));
    check("held_err", 32'(out_err), 32'(err));
  endtask

  task automatic release_word();
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("released_valid", 32'(out_valid), 32'd0);
    check("released_in_ready", 32'(in_ready), 32'd1);
    prev_closed = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    prev_closed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    do_reset();

    // Full word of legal digits, then hold it against changing input.
    ready_mode = 0;
    send_digit(4'h4, 1'b0, 1'b0, 1'b0);
    send_digit(4'h8, 1'b0, 1'b0, 1'b0);
    send_digit(4'h6, 1'b0, 1'b0, 1'b0);
    send_digit(4'hC, 1'b0, 1'b1, 1'b0);
    expect_held(16'h1539, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_digit = 4'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_bcd", 32'(out_bcd), 32'h1539);
      check("hold_count", 32'(out_count), 32'd4);
    end
    in_valid = 1'b0;
    ready_mode = 1;
    @(negedge clk);
    check("pre_handshake_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("post_handshake_valid", 32'(out_valid), 32'd0);
    check("post_handshake_in_ready", 32'(in_ready), 32'd1);
    prev_closed = 1'b0;

    // Early flush gives a right-aligned partial word.
    ready_mode = 0;
    send_digit(4'h5, 1'b0, 1'b0, 1'b0);
    send_digit(4'h3, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    expect_held(16'h0020, 2, 1'b0);
    release_word();

    // Illegal codes become marker nibbles and raise the error flag.
    ready_mode = 0;
    send_digit(4'h3, 1'b0, 1'b0, 1'b0);
    send_digit(4'hE, 1'b0, 1'b0, 1'b0);
    send_digit(4'h7, 1'b0, 1'b0, 1'b0);
    send_digit(4'hC, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    expect_held(16'h0F49, 4, 1'b1);
    release_word();

    // Overflow on an otherwise legal digit.
    ready_mode = 0;
    send_digit(4'h3, 1'b0, 1'b0, 1'b0);
    send_digit(4'h4, 1'b1, 1'b0, 1'b0);
    send_digit(4'h5, 1'b0, 1'b0, 1'b0);
    send_digit(4'h6, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    expect_held(16'h0F23, 4, 1'b1);
    release_word();

    // Reset mid-word discards the partial word.
    send_digit(4'($urandom_range(3, 12)), 1'b0, 1'b0, 1'b0);
    send_digit(4'($urandom_range(3, 12)), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    base = words_seen;
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) send_digit(4'h7, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    expect_held(16'h4444, 4, 1'b0);
    release_word();
    check("words_after_reset", 32'(words_seen), 32'(base + 1));

    // Back-to-back stream: exactly one in_ready bubble after each word.
    ready_mode = 1;
    prev_closed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_digit(4'($urandom_range(3, 12)), 1'b0, 1'($urandom_range(0, 4) == 0), 1'b1);
    end
    send_digit(4'($urandom_range(3, 12)), 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Randomized traffic with random backpressure and idle gaps.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_digit = 4'($urandom);
        @(negedge clk);
      end
      send_digit(4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 4) == 0), 1'b0);
    end
    send_digit(4'h5, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
